// File: rtl/rect_ascii_tx.sv
// Converts an (x,y,w,h) rectangle to a 12-byte ASCII decimal frame. Optional CR/LF trailer: RECT_ASCII_TX_CRLF_EN.
// First strobe follows a 1..19 cycle conversion; strobes are BYTE_CYC apart; start is ignored unless idle.
module rect_ascii_tx #(
  parameter int BYTE_CYC = 52080,
  parameter int CNT_W    = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] w,
  input  logic [9:0] h,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CONV = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] GAP  = 3'd3;
  localparam logic [2:0] FIN  = 3'd4;

`ifdef RECT_ASCII_TX_CRLF_EN
  localparam logic [3:0] LAST_IDX = 4'd13;
`else
  localparam logic [3:0] LAST_IDX = 4'd11;
`endif

  logic [2:0]       state;
  logic [9:0]       val   [4];
  logic [1:0]       phase [4];  // 0: hundreds, 1: tens, 2: finished
  logic [3:0]       dig   [12];
  logic [3:0]       idx;
  logic [3:0]       dig_sel;
  logic [CNT_W-1:0] gap_cnt;
  logic [7:0]       po_data_r;
  logic [7:0]       cur_byte;
  logic             conv_last;

  function automatic logic [9:0] sat(input logic [9:0] v);
    return (v > 10'd999) ? 10'd999 : v;
  endfunction

  // A field finishes in the current cycle once its residue drops below ten.
  always_comb begin
    conv_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (phase[i] != 2'd2 && val[i] >= 10'd10) conv_last = 1'b0;
    end
  end

  always_comb begin
    dig_sel  = (idx < 4'd12) ? idx : 4'd0;
    cur_byte = 8'h30 + {4'h0, dig[dig_sel]};
`ifdef RECT_ASCII_TX_CRLF_EN
    if (idx == 4'd12)      cur_byte = 8'h0D;
    else if (idx == 4'd13) cur_byte = 8'h0A;
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      po_data_r <= 8'h00;
      gap_cnt   <= '0;
      idx       <= 4'd0;
      for (int i = 0; i < 12; i++) dig[i] <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        val[i]   <= 10'd0;
        phase[i] <= 2'd0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            val[0] <= sat(x);
            val[1] <= sat(y);
            val[2] <= sat(w);
            val[3] <= sat(h);
            for (int i = 0; i < 4; i++) phase[i] <= 2'd0;
            for (int i = 0; i < 12; i++) dig[i] <= 4'd0;
            state <= CONV;
          end
        end
        CONV: begin
          // The first tens step shares the cycle that ends the hundreds phase.
          for (int i = 0; i < 4; i++) begin
            if (phase[i] == 2'd0 && val[i] >= 10'd100) begin
              val[i]     <= val[i] - 10'd100;
              dig[3*i]   <= dig[3*i] + 4'd1;
            end else if (phase[i] != 2'd2 && val[i] >= 10'd10) begin
              val[i]     <= val[i] - 10'd10;
              dig[3*i+1] <= dig[3*i+1] + 4'd1;
              phase[i]   <= 2'd1;
            end else if (phase[i] != 2'd2) begin
              dig[3*i+2] <= val[i][3:0];
              phase[i]   <= 2'd2;
            end
          end
          if (conv_last) state <= SEND;
        end
        SEND: begin
          po_data_r <= cur_byte;
          gap_cnt   <= '0;
          state     <= GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt + CNT_W'(1);
          if (gap_cnt == CNT_W'(BYTE_CYC - 2)) begin
            if (idx == LAST_IDX) begin
              state <= FIN;
            end else begin
              idx   <= idx + 4'd1;
              state <= SEND;
            end
          end
        end
        FIN: begin
          idx   <= 4'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign po_flag = (state == SEND);
  assign po_data = po_flag ? cur_byte : po_data_r;
  assign busy    = (state == CONV) || (state == SEND) || (state == GAP);
  assign done    = (state == FIN);

endmodule

// File: tb/tb_rect_ascii_tx.sv
// Directed bench for rect_ascii_tx with BYTE_CYC=16.
module tb_rect_ascii_tx;

  localparam int BC = 16;
`ifdef RECT_ASCII_TX_CRLF_EN
  localparam int FRAME_LEN = 14;
`else
  localparam int FRAME_LEN = 12;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] x = '0, y = '0, w = '0, h = '0;
  logic [7:0] po_data;
  logic       po_flag, busy, done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] byte_q[$];
  int         time_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;

  rect_ascii_tx #(.BYTE_CYC(BC), .CNT_W(8)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start),
    .x(x), .y(y), .w(w), .h(h),
    .po_data(po_data), .po_flag(po_flag), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc = cyc + 1;

  always @(negedge sys_clk) begin
    if (po_flag) begin
      byte_q.push_back(po_data);
      time_q.push_back(cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  function automatic logic [7:0] exp_byte(input string s, input int i);
    if (i < 12) return s[i];
    return (i == 12) ? 8'h0D : 8'h0A;
  endfunction

  task automatic clear_log();
    byte_q.delete();
    time_q.delete();
    done_cnt = 0;
  endtask

  // Called at a negedge; inputs are scrambled after the accept edge.
  task automatic pulse_start(input logic [9:0] a, b, c, d);
    x = a; y = b; w = c; h = d;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    x = 10'd555; y = 10'd666; w = 10'd777; h = 10'd888;
  endtask

  task automatic wait_done(output bit ok, output int busy_low);
    ok = 1'b0;
    busy_low = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge sys_clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (!busy) busy_low++;
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    total++; if (po_flag !== 1'b0) begin bad++; $display("FAIL reset_po_flag got %b exp 0", po_flag); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got %b exp 0", done); end
    total++; if (po_data !== 8'h00) begin bad++; $display("FAIL reset_po_data got %h exp 00", po_data); end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_basic();
    string s = "123045999000";
    bit ok; int bl;
    clear_log();
    pulse_start(10'd123, 10'd45, 10'd999, 10'd0);
    wait_done(ok, bl);
    @(negedge sys_clk);
    total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout got none exp done"); end
    total++; if (byte_q.size() != FRAME_LEN) begin bad++; $display("FAIL basic_count got %0d exp %0d", byte_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < byte_q.size(); i++) begin
      total++;
      if (byte_q[i] !== exp_byte(s, i)) begin bad++; $display("FAIL basic_byte%0d got %h exp %h", i, byte_q[i], exp_byte(s, i)); end
    end
    for (int i = 1; i < time_q.size(); i++) begin
      total++;
      if (time_q[i] - time_q[i-1] != BC) begin bad++; $display("FAIL basic_gap%0d got %0d exp %0d", i, time_q[i] - time_q[i-1], BC); end
    end
    if (time_q.size() > 0) begin
      total++; if (done_cyc - time_q[time_q.size()-1] != BC) begin bad++; $display("FAIL basic_done_gap got %0d exp %0d", done_cyc - time_q[time_q.size()-1], BC); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt got %0d exp 1", done_cnt); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got %b exp 0", done); end
    total++; if (bl != 0) begin bad++; $display("FAIL basic_busy_low got %0d exp 0", bl); end
  endtask

  task automatic test_saturation();
    string s = "999999100009";
    bit ok; int bl;
    clear_log();
    pulse_start(10'd1023, 10'd1000, 10'd100, 10'd9);
    wait_done(ok, bl);
    @(negedge sys_clk);
    total++; if (!ok) begin bad++; $display("FAIL sat_done_timeout got none exp done"); end
    total++; if (byte_q.size() != FRAME_LEN) begin bad++; $display("FAIL sat_count got %0d exp %0d", byte_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < byte_q.size(); i++) begin
      total++;
      if (byte_q[i] !== exp_byte(s, i)) begin bad++; $display("FAIL sat_byte%0d got %h exp %h", i, byte_q[i], exp_byte(s, i)); end
    end
  endtask

  task automatic test_zero();
    string s = "000000000000";
    bit ok; int bl;
    clear_log();
    pulse_start(10'd0, 10'd0, 10'd0, 10'd0);
    wait_done(ok, bl);
    @(negedge sys_clk);
    total++; if (!ok) begin bad++; $display("FAIL zero_done_timeout got none exp done"); end
    total++; if (byte_q.size() != FRAME_LEN) begin bad++; $display("FAIL zero_count got %0d exp %0d", byte_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < byte_q.size(); i++) begin
      total++;
      if (byte_q[i] !== exp_byte(s, i)) begin bad++; $display("FAIL zero_byte%0d got %h exp %h", i, byte_q[i], exp_byte(s, i)); end
    end
  endtask

  task automatic test_start_ignored();
    string s = "111222333444";
    bit ok, hit; int bl;
    clear_log();
    hit = 1'b0;
    pulse_start(10'd111, 10'd222, 10'd333, 10'd444);
    for (int k = 0; k < 400; k++) begin
      @(negedge sys_clk);
      if (byte_q.size() >= 6) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL ign_reach_byte5 got %0d strobes exp 6", byte_q.size()); end
    pulse_start(10'd1, 10'd2, 10'd3, 10'd4);
    wait_done(ok, bl);
    @(negedge sys_clk);
    total++; if (!ok) begin bad++; $display("FAIL ign_done_timeout got none exp done"); end
    total++; if (byte_q.size() != FRAME_LEN) begin bad++; $display("FAIL ign_count got %0d exp %0d", byte_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < byte_q.size(); i++) begin
      total++;
      if (byte_q[i] !== exp_byte(s, i)) begin bad++; $display("FAIL ign_byte%0d got %h exp %h", i, byte_q[i], exp_byte(s, i)); end
    end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ign_done_cnt got %0d exp 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    string s = "007080500999";
    bit ok, hit; int bl;
    clear_log();
    hit = 1'b0;
    pulse_start(10'd321, 10'd654, 10'd987, 10'd12);
    for (int k = 0; k < 400; k++) begin
      @(negedge sys_clk);
      if (byte_q.size() >= 8) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL rst_reach_byte7 got %0d strobes exp 8", byte_q.size()); end
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    total++; if (po_flag !== 1'b0) begin bad++; $display("FAIL rst_mid_po_flag got %b exp 0", po_flag); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_mid_done got %b exp 0", done); end
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    total++; if (byte_q.size() != 8) begin bad++; $display("FAIL rst_mid_strobes got %0d exp 8", byte_q.size()); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL rst_mid_done_cnt got %0d exp 0", done_cnt); end
    clear_log();
    pulse_start(10'd7, 10'd80, 10'd500, 10'd999);
    wait_done(ok, bl);
    @(negedge sys_clk);
    total++; if (!ok) begin bad++; $display("FAIL rst_fresh_timeout got none exp done"); end
    total++; if (byte_q.size() != FRAME_LEN) begin bad++; $display("FAIL rst_fresh_count got %0d exp %0d", byte_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < byte_q.size(); i++) begin
      total++;
      if (byte_q[i] !== exp_byte(s, i)) begin bad++; $display("FAIL rst_fresh_byte%0d got %h exp %h", i, byte_q[i], exp_byte(s, i)); end
    end
  endtask

  task automatic test_back_to_back();
    string s = "042017256600";
    bit ok; int bl;
    clear_log();
    pulse_start(10'd1, 10'd2, 10'd3, 10'd4);
    wait_done(ok, bl);
    total++; if (!ok) begin bad++; $display("FAIL b2b_a_timeout got none exp done"); end
    // Start on the done cycle must be dropped.
    x = 10'd9; y = 10'd9; w = 10'd9; h = 10'd9;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    clear_log();
    @(negedge sys_clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_done_start_busy got %b exp 0", busy); end
    repeat (30) @(negedge sys_clk);
    total++; if (byte_q.size() != 0) begin bad++; $display("FAIL b2b_done_start_strobes got %0d exp 0", byte_q.size()); end
    pulse_start(10'd5, 10'd6, 10'd7, 10'd8);
    wait_done(ok, bl);
    total++; if (!ok) begin bad++; $display("FAIL b2b_b_timeout got none exp done"); end
    clear_log();
    @(negedge sys_clk);
    pulse_start(10'd42, 10'd17, 10'd256, 10'd600);
    @(negedge sys_clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_after_done_busy got %b exp 1", busy); end
    wait_done(ok, bl);
    @(negedge sys_clk);
    total++; if (!ok) begin bad++; $display("FAIL b2b_c_timeout got none exp done"); end
    total++; if (byte_q.size() != FRAME_LEN) begin bad++; $display("FAIL b2b_count got %0d exp %0d", byte_q.size(), FRAME_LEN); end
    for (int i = 0; i < FRAME_LEN && i < byte_q.size(); i++) begin
      total++;
      if (byte_q[i] !== exp_byte(s, i)) begin bad++; $display("FAIL b2b_byte%0d got %h exp %h", i, byte_q[i], exp_byte(s, i)); end
    end
  endtask

  initial begin
    @(negedge sys_clk);
    test_reset();
    test_basic();
    test_saturation();
    test_zero();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rect_ascii_tx.md
Name: rect_ascii_tx

Overview:
Formats a rectangle descriptor (x, y, w, h) into the 12-byte ASCII decimal frame used by our UART link. Each field is sent as three digits, most significant digit first, in the order x, y, w, h. This block is the transmit-side counterpart of the rectangle parser. It sits between the coordinate-producing logic and uart_tx, and paces bytes with a fixed per-byte cycle budget.

Parameters:
BYTE_CYC, 52080, clock cycles between successive po_flag pulses (10 bits × 5208 cycles at 50 MHz / 9600 baud); legal values are 2 or greater.
CNT_W, 16, width of the byte-gap counter; must satisfy 2^CNT_W > BYTE_CYC.

Ports:
sys_clk  input  1  system clock; all logic on rising edge
sys_rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle request to send a frame
x  input  10  x coordinate, binary
y  input  10  y coordinate, binary
w  input  10  width, binary
h  input  10  height, binary
po_data  output  8  ASCII byte to uart_tx; valid when po_flag is high
po_flag  output  1  single-cycle byte strobe to uart_tx
busy  output  1  high while a frame is in progress
done  output  1  single-cycle pulse when the frame completes

Behaviour:
- Reset (synchronous, sys_rst_n==0 at a clock edge): state=IDLE, po_data=8'h00, po_flag=0, busy=0, done=0, gap counter=0, byte index=0, digit buffer cleared. A reset mid-frame aborts the frame immediately; no further po_flag is issued and done is not asserted.
- States: IDLE, CONV, SEND, GAP, FIN.
- IDLE: if start==1, latch x/y/w/h into working registers and enter CONV. busy goes high on the next cycle.
  - Saturation at latch: any input greater than 999 is replaced by 999.
- CONV: all four fields are converted in parallel by repeated subtraction.
  - Hundreds phase: while val>=100, subtract 100 and increment the hundreds digit, one step per cycle.
  - Tens phase: same procedure with 10.
  - The remainder becomes the ones digit.
  - Leave CONV when all four fields are finished. Worst case is 19 cycles; latency does not depend on data order between fields.
  - Digits are stored in a 12-entry buffer of 4-bit values: index 0..2 = x (hundreds, tens, ones), 3..5 = y, 6..8 = w, 9..11 = h.
- SEND: for one cycle, drive po_data = 8'h30 + digit[idx] and po_flag = 1, load the gap counter with 0, then go to GAP.
- GAP: increment the gap counter each cycle. When it reaches BYTE_CYC-2:
  - if idx is the last byte, go to FIN;
  - otherwise increment idx and go to SEND.
  - Result: po_flag rising edges are exactly BYTE_CYC cycles apart.
- FIN: for one cycle, done=1 and busy=0. Clear idx and return to IDLE.
- po_data holds its last value between strobes; po_flag is 0 outside SEND.
- start is ignored whenever state != IDLE; there is no queuing. If start coincides with the FIN cycle, it is ignored.
- Inputs are sampled only at the start-accept edge; later changes to x/y/w/h do not affect the frame in flight.
- Frame latency: first po_flag occurs 1 (IDLE→CONV) + CONV cycles + 1 after start. Total frame duration is deterministic given the data.

Optional Feature:
RECT_ASCII_TX_CRLF_EN
- Defined: after byte 11, two more bytes are sent with the same pacing, 8'h0D then 8'h0A (frame = 14 bytes, last index 13); done follows the gap after 8'h0A.
- Undefined: the frame is exactly 12 bytes, last index 11, and the CR/LF logic is absent.

Test Plan:
- BYTE_CYC=16; x=123, y=45, w=999, h=0, pulse start → po_data sequence "123045999000" (0x31,0x32,0x33,0x30,0x34,0x35,0x39,0x39,0x39,0x30,0x30,0x30); consecutive po_flag exactly 16 cycles apart; one done pulse 16 cycles after the last strobe; busy high throughout.
- Saturation: x=1023, y=1000, w=100, h=9 → "999999100009".
- Start pulsed again during byte 5 with different values → ignored; the frame is unchanged and the count of po_flag pulses is exactly 12.
- Reset asserted during GAP after byte 7 → next cycle po_flag=0, busy=0, done=0, state IDLE; a fresh start then sends a full correct frame.
- Back-to-back: start asserted the cycle after done → second frame accepted; start on the done cycle → ignored.
- With RECT_ASCII_TX_CRLF_EN: x=y=w=h=0 → "000000000000" followed by 0x0D, 0x0A; 14 strobes, then done.
